// File: rtl/tail_light_input_conditioner.sv
// tail_light_input_conditioner
// Turns raw, asynchronous, bouncing driver switches into clean, synchronous
// brake / turn_right / turn_left levels for the tail-light sequencer.
// Each channel: synchronizer -> debouncer -> output register (or stalk FSM).
// Optional feature macro: TLC_HAZARD_EN adds the hazard_sw channel, which
// forces both turn outputs high while the debounced hazard level is 1.
module tail_light_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic brake_sw,
    input  logic turn_right_sw,
    input  logic turn_left_sw,
`ifdef TLC_HAZARD_EN
    input  logic hazard_sw,
`endif
    output logic brake,
    output logic turn_right,
    output logic turn_left,
    output logic stalk_fault
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The count flips db on the edge where it would reach DEBOUNCE_CYCLES,
    // so the last stored value before the flip is DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam int CH_BRAKE = 0;
    localparam int CH_RIGHT = 1;
    localparam int CH_LEFT  = 2;
`ifdef TLC_HAZARD_EN
    localparam int CH_HAZARD = 3;
    localparam int NCH       = 4;
`else
    localparam int NCH       = 3;
`endif

    logic [NCH-1:0] w_raw;
    logic [NCH-1:0] w_db;
    logic           w_hazard;

`ifdef TLC_HAZARD_EN
    assign w_raw    = {hazard_sw, turn_left_sw, turn_right_sw, brake_sw};
    assign w_hazard = w_db[CH_HAZARD];
`else
    assign w_raw    = {turn_left_sw, turn_right_sw, brake_sw};
    assign w_hazard = 1'b0;
`endif

    // One synchronizer + debouncer per switch channel.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_db;
        logic                   w_sync;

        assign w_sync  = r_sync[SYNC_STAGES-1];
        assign w_db[g] = r_db;

        // Shift the raw switch level through the synchronizer chain.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_sync <= '0;
            else     r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
        end

        // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
                r_db  <= 1'b0;
            end else if (w_sync == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_db  <= ~r_db;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RIGHT = 2'd1,
        S_LEFT  = 2'd2,
        S_FAULT = 2'd3
    } stalk_state_t;

    stalk_state_t r_state;
    stalk_state_t w_next;
    logic         w_db_r;
    logic         w_db_l;

    assign w_db_r = w_db[CH_RIGHT];
    assign w_db_l = w_db[CH_LEFT];

    // Stalk interlock state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic: first direction wins, both-at-once from IDLE is a fault.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_db_r && w_db_l)       w_next = S_FAULT;
                else if (w_db_r)            w_next = S_RIGHT;
                else if (w_db_l)            w_next = S_LEFT;
                else                        w_next = S_IDLE;
            end
            S_RIGHT: if (!w_db_r)           w_next = S_IDLE;
            S_LEFT:  if (!w_db_l)           w_next = S_IDLE;
            S_FAULT: if (!w_db_r && !w_db_l) w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    logic r_brake;
    logic r_turn_right;
    logic r_turn_left;
    logic r_stalk_fault;

    // Output registers: decoded from the next state so turn outputs share
    // the brake path's one-register latency after the debouncer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_brake       <= 1'b0;
            r_turn_right  <= 1'b0;
            r_turn_left   <= 1'b0;
            r_stalk_fault <= 1'b0;
        end else begin
            r_brake       <= w_db[CH_BRAKE];
            r_turn_right  <= (w_next == S_RIGHT) | w_hazard;
            r_turn_left   <= (w_next == S_LEFT)  | w_hazard;
            r_stalk_fault <= (w_next == S_FAULT);
        end
    end

    assign brake       = r_brake;
    assign turn_right  = r_turn_right;
    assign turn_left   = r_turn_left;
    assign stalk_fault = r_stalk_fault;

endmodule

// File: tb/tb_tail_light_input_conditioner.sv
// Testbench for tail_light_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Directed scenarios with constant expectations, then randomized switch
// activity compared every cycle against a behavioural model.
module tb_tail_light_input_conditioner;

  localparam int D = 4;
  localparam int S = 2;

  localparam int OWN_NONE  = 0;
  localparam int OWN_RIGHT = 1;
  localparam int OWN_LEFT  = 2;
  localparam int OWN_FAULT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic brake_sw = 1'b0;
  logic turn_right_sw = 1'b0;
  logic turn_left_sw = 1'b0;
`ifdef TLC_HAZARD_EN
  logic hazard_sw = 1'b0;
`endif
  logic brake;
  logic turn_right;
  logic turn_left;
  logic stalk_fault;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [3:0] raw_q[$];   // raw samples still travelling through the synchronizer
  logic [3:0] m_db;       // debounced levels: 0 brake, 1 right, 2 left, 3 hazard
  int         m_run[4];   // consecutive disagreeing cycles per channel
  int         m_owner;
  logic       m_brake, m_tr, m_tl, m_fault;

  tail_light_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .brake_sw(brake_sw),
    .turn_right_sw(turn_right_sw),
    .turn_left_sw(turn_left_sw),
`ifdef TLC_HAZARD_EN
    .hazard_sw(hazard_sw),
`endif
    .brake(brake),
    .turn_right(turn_right),
    .turn_left(turn_left),
    .stalk_fault(stalk_fault)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [3:0] raw_now();
`ifdef TLC_HAZARD_EN
    return {hazard_sw, turn_left_sw, turn_right_sw, brake_sw};
`else
    return {1'b0, turn_left_sw, turn_right_sw, brake_sw};
`endif
  endfunction

  // Who owns the stalk given its current owner and the debounced contacts.
  function automatic int next_owner(input int own, input logic r, input logic l);
    case (own)
      OWN_NONE:  return (r && l) ? OWN_FAULT : r ? OWN_RIGHT : l ? OWN_LEFT : OWN_NONE;
      OWN_RIGHT: return r ? OWN_RIGHT : OWN_NONE;
      OWN_LEFT:  return l ? OWN_LEFT : OWN_NONE;
      default:   return (r || l) ? OWN_FAULT : OWN_NONE;
    endcase
  endfunction

  task automatic model_reset();
    raw_q = {};
    for (int i = 0; i < S; i++) raw_q.push_back(4'b0000);
    m_db = 4'b0000;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_owner = OWN_NONE;
    m_brake = 1'b0;
    m_tr = 1'b0;
    m_tl = 1'b0;
    m_fault = 1'b0;
  endtask

  // One rising edge of the model: outputs follow the debounced levels held
  // before the edge, then debounced levels update from the synchronized sample.
  task automatic model_edge();
    logic [3:0] s;
    logic [3:0] db_old;
    s = raw_q.pop_front();
    raw_q.push_back(raw_now());
    db_old = m_db;
    m_owner = next_owner(m_owner, db_old[1], db_old[2]);
    m_brake = db_old[0];
    m_tr = (m_owner == OWN_RIGHT) || db_old[3];
    m_tl = (m_owner == OWN_LEFT) || db_old[3];
    m_fault = (m_owner == OWN_FAULT);
    for (int ch = 0; ch < 4; ch++) begin
      if (s[ch] != m_db[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == D) begin
          m_db[ch] = ~m_db[ch];
          m_run[ch] = 0;
        end
      end else begin
        m_run[ch] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("model_brake", brake, m_brake);
    chk("model_turn_right", turn_right, m_tr);
    chk("model_turn_left", turn_left, m_tl);
    chk("model_stalk_fault", stalk_fault, m_fault);
  endtask

  // Driver: one clock, model advanced on the edge, outputs sampled at negedge.
  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_sw(input logic b, input logic r, input logic l);
    brake_sw = b;
    turn_right_sw = r;
    turn_left_sw = l;
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_brake", brake, 1'b0);
    chk("rst_turn_right", turn_right, 1'b0);
    chk("rst_turn_left", turn_left, 1'b0);
    chk("rst_stalk_fault", stalk_fault, 1'b0);
    @(negedge clk);
    steps(2);
    rst = 1'b0;
  endtask

  task automatic settle();
    set_sw(1'b0, 1'b0, 1'b0);
`ifdef TLC_HAZARD_EN
    hazard_sw = 1'b0;
`endif
    steps(14);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    check_model();
    steps(2);
    rst = 1'b0;

    // Reset with all switches held high, mid-activity
    set_sw(1'b1, 1'b1, 1'b1);
    steps(10);
    chk("pre_rst_brake", brake, 1'b1);
    chk("pre_rst_fault", stalk_fault, 1'b1);
    async_reset();
    steps(6);
    chk("rel6_brake", brake, 1'b0);
    chk("rel6_fault", stalk_fault, 1'b0);
    step();
    chk("rel7_brake", brake, 1'b1);
    chk("rel7_turn_right", turn_right, 1'b0);
    chk("rel7_turn_left", turn_left, 1'b0);
    chk("rel7_fault", stalk_fault, 1'b1);

    // Bounce on the right contact never reaches the output
    settle();
    for (int i = 0; i < 10; i++) begin
      turn_right_sw = (i % 2 == 0);
      for (int k = 0; k < 2; k++) begin
        step();
        chk("bounce_turn_right", turn_right, 1'b0);
      end
    end
    turn_right_sw = 1'b1;
    steps(6);
    chk("bounce_hold6", turn_right, 1'b0);
    step();
    chk("bounce_hold7", turn_right, 1'b1);

    // Interlock: right owns the stalk, late left is ignored
    steps(13);
    turn_left_sw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("lock_turn_right", turn_right, 1'b1);
      chk("lock_turn_left", turn_left, 1'b0);
    end
    turn_right_sw = 1'b0;
    steps(6);
    chk("lock_rel6_right", turn_right, 1'b1);
    step();
    chk("lock_rel7_right", turn_right, 1'b0);
    chk("lock_rel7_left", turn_left, 1'b0);
    step();
    chk("lock_rel8_left", turn_left, 1'b1);

    // Simultaneous contacts: fault until both released
    settle();
    set_sw(1'b0, 1'b1, 1'b1);
    steps(6);
    chk("fault6", stalk_fault, 1'b0);
    step();
    chk("fault7", stalk_fault, 1'b1);
    chk("fault7_right", turn_right, 1'b0);
    chk("fault7_left", turn_left, 1'b0);
    turn_left_sw = 1'b0;
    steps(10);
    chk("fault_left_rel", stalk_fault, 1'b1);
    chk("fault_left_rel_right", turn_right, 1'b0);
    turn_right_sw = 1'b0;
    steps(6);
    chk("fault_clear6", stalk_fault, 1'b1);
    step();
    chk("fault_clear7", stalk_fault, 1'b0);

    // Brake with a turn
    settle();
    set_sw(1'b1, 1'b0, 1'b1);
    steps(6);
    chk("bt6_brake", brake, 1'b0);
    chk("bt6_left", turn_left, 1'b0);
    step();
    chk("bt7_brake", brake, 1'b1);
    chk("bt7_left", turn_left, 1'b1);
    brake_sw = 1'b0;
    steps(7);
    chk("bt_drop_brake", brake, 1'b0);
    chk("bt_drop_left", turn_left, 1'b1);

`ifdef TLC_HAZARD_EN
    // Hazard over an active left turn
    hazard_sw = 1'b1;
    steps(6);
    chk("hz6_right", turn_right, 1'b0);
    step();
    chk("hz7_right", turn_right, 1'b1);
    chk("hz7_left", turn_left, 1'b1);
    chk("hz7_fault", stalk_fault, 1'b0);
    steps(5);
    hazard_sw = 1'b0;
    steps(6);
    chk("hz_rel6_right", turn_right, 1'b1);
    step();
    chk("hz_rel7_right", turn_right, 1'b0);
    chk("hz_rel7_left", turn_left, 1'b1);
`endif

    // Randomized switch activity with occasional mid-run resets
    for (int it = 0; it < 300; it++) begin
      set_sw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`ifdef TLC_HAZARD_EN
      if ($urandom_range(0, 3) == 0) hazard_sw = ~hazard_sw;
`endif
      if ($urandom_range(0, 40) == 0) async_reset();
      steps($urandom_range(1, 9));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
